// File: rtl/can_rx_fetch.sv
`timescale 1ns/1ps
// can_rx_fetch: interrupt-driven receive engine for an SJA1000 (PeliCAN mode).
// On a low can_int_n level it reads IR, unloads the RX buffer one byte at a
// time through the 32-bit register port, releases the buffer, then presents
// one decoded frame to the consumer with valid/ready.
//
// Optional build macro: CAN_RX_TIMEOUT_EN. When defined, a watchdog aborts a
// read that gets no response within TO_CYCLES cycles and pulses err_o.
//
// Ports:
//   sys_clk, rst          clock, asynchronous active-high reset
//   int_n_i               synchronized can_int_n (active low, level)
//   addr_32b_o/din_32b_o  register address / write data ([7:0] used)
//   wren_o/rden_o         one-cycle write / read requests
//   dout_32b_i/_valid_i   read data ([7:0] used) and its one-cycle strobe
//   busy_o                high whenever the engine owns the register port
//   frm_*                 decoded frame, valid/ready handshake
//   irq_other_o           pulse when IR was read without RI set
//   ir_o                  last IR value read
//   err_o                 pulse on read timeout (0 without the macro)
module can_rx_fetch #(
    parameter int unsigned WR_WAIT   = 16,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        int_n_i,
    output logic [31:0] addr_32b_o,
    output logic        wren_o,
    output logic        rden_o,
    output logic [31:0] din_32b_o,
    input  logic [31:0] dout_32b_i,
    input  logic        dout_32b_valid_i,
    output logic        busy_o,
    output logic        frm_valid_o,
    input  logic        frm_ready_i,
    output logic        frm_ext_o,
    output logic        frm_rtr_o,
    output logic [3:0]  frm_dlc_o,
    output logic [28:0] frm_id_o,
    output logic [63:0] frm_data_o,
    output logic        irq_other_o,
    output logic [7:0]  ir_o,
    output logic        err_o
);

    localparam int unsigned NB_MAX = 13;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WW_W   = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;

    localparam logic [7:0] ADDR_CMD = 8'd1;
    localparam logic [7:0] ADDR_IR  = 8'd3;
    localparam logic [7:0] ADDR_RXB = 8'd16;
    localparam logic [7:0] CMD_RRB  = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_IR,
        ST_W_IR,
        ST_RD_B,
        ST_W_B,
        ST_WR_RRB,
        ST_WAIT_W
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WW_W-1:0]   wait_q;
    logic [7:0]        byte_q [NB_MAX];
    logic              ff_q;
    logic              rtr_q;
    logic [3:0]        dlc_q;
    logic [7:0]        addr_q;
    logic [7:0]        din_q;
    logic              rden_q;
    logic              wren_q;
    logic              irq_other_q;
    logic [7:0]        ir_q;
    logic              frm_valid_q;
    logic              frm_ext_q;
    logic              frm_rtr_q;
    logic [3:0]        frm_dlc_q;
    logic [28:0]       frm_id_q;
    logic [63:0]       frm_data_q;

    logic [3:0]        data_len_c;
    logic [CNT_W-1:0]  last_idx_c;
    logic [28:0]       frm_id_d;
    logic [63:0]       frm_data_d;

    // Only the low byte of read data carries register content.
    logic unused_ok;

`ifdef CAN_RX_TIMEOUT_EN
    localparam int unsigned TO_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    logic            to_hit_c;

    assign to_hit_c  = (to_cnt_q == TO_W'(TO_CYCLES - 1));
    assign err_o     = err_q;
    assign unused_ok = &{1'b0, dout_32b_i[31:8]};
`else
    assign err_o     = 1'b0;
    assign unused_ok = &{1'b0, dout_32b_i[31:8], (TO_CYCLES != 0)};
`endif

    assign addr_32b_o  = {24'd0, addr_q};
    assign din_32b_o   = {24'd0, din_q};
    assign rden_o      = rden_q;
    assign wren_o      = wren_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign frm_valid_o = frm_valid_q;
    assign frm_ext_o   = frm_ext_q;
    assign frm_rtr_o   = frm_rtr_q;
    assign frm_dlc_o   = frm_dlc_q;
    assign frm_id_o    = frm_id_q;
    assign frm_data_o  = frm_data_q;
    assign irq_other_o = irq_other_q;
    assign ir_o        = ir_q;

    // Frame length from the latched frame-info byte; DLC above 8 still moves 8 bytes.
    always_comb begin
        data_len_c = 4'd0;
        if (!rtr_q) begin
            data_len_c = (dlc_q > 4'd8) ? 4'd8 : dlc_q;
        end
        last_idx_c = (ff_q ? 4'd4 : 4'd2) + data_len_c;
    end

    // Identifier and payload assembly; bytes beyond the data length read as zero.
    always_comb begin
        frm_id_d   = '0;
        frm_data_d = '0;
        if (ff_q) begin
            frm_id_d = {byte_q[1], byte_q[2], byte_q[3], byte_q[4][7:3]};
        end else begin
            frm_id_d = {18'd0, byte_q[1], byte_q[2][7:5]};
        end
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < data_len_c) begin
                frm_data_d[63 - 8*i -: 8] = ff_q ? byte_q[5 + i] : byte_q[3 + i];
            end
        end
    end

    // Fetch sequencer with registered request and frame outputs.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            ff_q        <= 1'b0;
            rtr_q       <= 1'b0;
            dlc_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            irq_other_q <= 1'b0;
            ir_q        <= '0;
            frm_valid_q <= 1'b0;
            frm_ext_q   <= 1'b0;
            frm_rtr_q   <= 1'b0;
            frm_dlc_q   <= '0;
            frm_id_q    <= '0;
            frm_data_q  <= '0;
            for (int i = 0; i < int'(NB_MAX); i++) begin
                byte_q[i] <= '0;
            end
`ifdef CAN_RX_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            irq_other_q <= 1'b0;
`ifdef CAN_RX_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            if (frm_valid_q && frm_ready_i) begin
                frm_valid_q <= 1'b0;
            end

            case (state_q)
                // A pending frame blocks new fetches, back-pressuring the RX FIFO.
                ST_IDLE: begin
                    if (!int_n_i && !frm_valid_q) begin
                        state_q <= ST_RD_IR;
                    end
                end

                ST_RD_IR: begin
                    addr_q  <= ADDR_IR;
                    rden_q  <= 1'b1;
                    state_q <= ST_W_IR;
`ifdef CAN_RX_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end

                ST_W_IR: begin
                    if (dout_32b_valid_i) begin
                        ir_q <= dout_32b_i[7:0];
                        if (dout_32b_i[0]) begin
                            cnt_q   <= '0;
                            state_q <= ST_RD_B;
                        end else begin
                            irq_other_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
`ifdef CAN_RX_TIMEOUT_EN
                    else if (to_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end

                ST_RD_B: begin
                    addr_q  <= ADDR_RXB + {4'd0, cnt_q};
                    rden_q  <= 1'b1;
                    state_q <= ST_W_B;
`ifdef CAN_RX_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                end

                // Byte 0 is frame info; the last index is never 0, so stale info is harmless there.
                ST_W_B: begin
                    if (dout_32b_valid_i) begin
                        byte_q[cnt_q] <= dout_32b_i[7:0];
                        if (cnt_q == '0) begin
                            ff_q  <= dout_32b_i[7];
                            rtr_q <= dout_32b_i[6];
                            dlc_q <= dout_32b_i[3:0];
                        end
                        if ((cnt_q != '0) && (cnt_q == last_idx_c)) begin
                            state_q <= ST_WR_RRB;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= ST_RD_B;
                        end
                    end
`ifdef CAN_RX_TIMEOUT_EN
                    else if (to_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
`endif
                end

                ST_WR_RRB: begin
                    addr_q  <= ADDR_CMD;
                    din_q   <= CMD_RRB;
                    wren_q  <= 1'b1;
                    wait_q  <= '0;
                    state_q <= ST_WAIT_W;
                end

                // Writes are unacknowledged, so hold off a fixed time before handing over.
                ST_WAIT_W: begin
                    if (wait_q == WW_W'(WR_WAIT - 1)) begin
                        frm_ext_q   <= ff_q;
                        frm_rtr_q   <= rtr_q;
                        frm_dlc_q   <= dlc_q;
                        frm_id_q    <= frm_id_d;
                        frm_data_q  <= frm_data_d;
                        frm_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_q <= wait_q + WW_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/can_rx_fetch.md
Name: can_rx_fetch

Overview:
- Interrupt-driven receive engine sitting directly upstream of the CAN bus-interface block; it drives that block's 32-bit register request port.
- On can_int_n it reads the SJA1000 (PeliCAN mode) interrupt register and unloads the RX buffer byte-by-byte.
- It then issues Release Receive Buffer and presents one decoded frame to the consumer with valid/ready.
- An external mux grants it the register port whenever busy_o is high.

Parameters:
- WR_WAIT, 16: cycles after a wren_o pulse before the next request; write completion is not acknowledged.
- TO_CYCLES, 1024: read-response watchdog limit; used only with CAN_RX_TIMEOUT_EN.

Ports:
- sys_clk, in, 1: single clock.
- rst, in, 1: asynchronous reset, active high.
- int_n_i, in, 1: can_int_n, already synchronized; active low.
- addr_32b_o, out, 32: register address; [7:0] used, [31:8] = 0.
- wren_o, out, 1: one-cycle write request.
- rden_o, out, 1: one-cycle read request.
- din_32b_o, out, 32: write data; [7:0] used, [31:8] = 0.
- dout_32b_i, in, 32: read data; [7:0] used.
- dout_32b_valid_i, in, 1: read data valid, one cycle.
- busy_o, out, 1: high in every state except IDLE.
- frm_valid_o, out, 1: decoded frame available.
- frm_ready_i, in, 1: consumer accepts the frame.
- frm_ext_o, out, 1: extended frame format (FF bit).
- frm_rtr_o, out, 1: remote frame.
- frm_dlc_o, out, 4: raw DLC.
- frm_id_o, out, 29: identifier; SFF frames use [10:0], upper bits zero.
- frm_data_o, out, 64: payload; byte0 in [63:56]; unused bytes zero.
- irq_other_o, out, 1: one-cycle pulse when IR was read with RI = 0.
- ir_o, out, 8: last IR value read.
- err_o, out, 1: one-cycle pulse on read timeout.

Behaviour:
- Reset: all outputs 0 and state = IDLE, including mid-transaction. Any outstanding response arriving after reset is ignored because the FSM is in IDLE.
- IDLE: when int_n_i = 0 and frm_valid_o = 0, go to RD_IR.
- RD_IR: drive addr = 3 with rden_o for exactly one cycle, then go to W_IR.
- W_IR: wait for dout_32b_valid_i, then capture ir_o.
  - If bit0 (RI) = 1: cnt = 0, go to RD_B.
  - If bit0 = 0: pulse irq_other_o and return to IDLE.
- RD_B: issue rden_o with addr = 16 + cnt, then go to W_B.
- W_B: wait for dout_32b_valid_i and store the byte at index cnt.
  - On cnt = 0 (frame info): latch FF = b[7], RTR = b[6], DLC = b[3:0].
  - Compute N = 1 + (FF ? 4 : 2) + (RTR ? 0 : min(DLC, 8)). DLC values 9..15 are clamped to 8 for the byte count, but frm_dlc_o reports the raw value.
  - If cnt = N-1, go to WR_RRB; otherwise cnt++ and return to RD_B.
- Byte counts: minimum N = 3 (SFF RTR); maximum N = 13 (EFF, 8 data bytes).
- WR_RRB: wren_o pulses one cycle with addr = 1 and din = 0x04. Then wait WR_WAIT cycles in state WAIT_W.
- WAIT_W to IDLE: on the last wait cycle, load the output register and set frm_valid_o = 1. The FSM then returns to IDLE.
- Identifier assembly:
  - SFF: id[10:0] = {b1, b2[7:5]}.
  - EFF: id[28:0] = {b1, b2, b3, b4[7:3]}.
- Data bytes start at b3 for SFF and b5 for EFF.
- Output handshake:
  - frm_valid_o stays high with all frm_* stable until a cycle with frm_ready_i = 1.
  - On that cycle frm_valid_o clears at the next edge.
  - No new fetch starts while valid is high. This applies backpressure to the SJA1000's 64-byte RX FIFO.
- IRQ level handling: int_n_i is sampled as a level. If it is still low after the frame is consumed, the FSM re-enters RD_IR.
- Request spacing: at most one request outstanding, and rden_o and wren_o are never high together.
- Unexpected responses: dout_32b_valid_i outside the W_IR and W_B states is ignored.

Optional Feature:
- Macro: CAN_RX_TIMEOUT_EN.
- Enabled: a counter runs in W_IR and W_B and resets on each request. On reaching TO_CYCLES, the FSM pulses err_o, discards the partial frame (no frm_valid_o, no RRB) and returns to IDLE.
- Disabled: no counter; W_IR and W_B wait indefinitely, and err_o is tied to 0.

Test Plan:
- SFF data frame: IR = 0x01, bytes 0x03,0x24,0x60,0xAA,0xBB,0xCC. Expect reads at addrs 3,16..21, then a write of 0x04 to addr 1. Frame has ext = 0, rtr = 0, dlc = 3, id = 0x123, data = 0xAABBCC0000000000.
- EFF 8-byte frame: info = 0x88, ID bytes 0x12,0x34,0x56,0x78, data 0x01..0x08. Expect 13 reads (addrs 16..28) and id = 0x02468ACF. Hold frm_ready_i low 50 cycles: outputs stable and no rden_o seen.
- RTR SFF: info = 0x48 (dlc 8). Expect exactly 3 RX reads, rtr = 1, dlc = 8, data = 0.
- IR = 0x04: expect irq_other_o pulse, ir_o = 0x04, no RX reads, no wren_o.
- int_n_i held low across two frames: second RD_IR is issued only after frm_ready_i handshake. Assert rst during W_B: all outputs 0 immediately, and a later dout_32b_valid_i is ignored.
- With CAN_RX_TIMEOUT_EN and TO_CYCLES = 64: withhold response on byte 2. Expect err_o pulse at cycle 64, no frame, no RRB write, busy_o = 0.
